// File: rtl/rf_wb_sink.sv
// Register-file write-back sink: WB write port, two registered read ports with
// write bypass, hardwired R0 and a pending-write scoreboard. 1-cycle read latency; stall holds outputs.
module rf_wb_sink #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_DM_WB,
    input  logic [ADDR_W-1:0] dst_addr_DM_WB,
    input  logic [DATA_W-1:0] rf_w_data_DM_WB,
    input  logic              re0,
    input  logic              re1,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic              stall_ID_EX,
    input  logic              pend_set,
    input  logic [ADDR_W-1:0] pend_addr,
    output logic [DATA_W-1:0] p0,
    output logic [DATA_W-1:0] p1,
    output logic              p0_busy,
    output logic              p1_busy
);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [DATA_W-1:0]   p0_q, p0_d, p1_q, p1_d;
    logic                p0_busy_q, p0_busy_d, p1_busy_q, p1_busy_d;
    logic                wr_vld, set_vld;

    assign wr_vld  = we_DM_WB && (dst_addr_DM_WB != '0);
    assign set_vld = pend_set && (pend_addr != '0);

    always_comb begin
        busy_d    = busy_q;
        p0_d      = p0_q;
        p1_d      = p1_q;
        p0_busy_d = p0_busy_q;
        p1_busy_d = p1_busy_q;

        // Set is applied after clear so a new producer stays outstanding.
        if (wr_vld) busy_d[dst_addr_DM_WB] = 1'b0;
        if (set_vld) busy_d[pend_addr] = 1'b1;
        busy_d[0] = 1'b0;

        if (re0 && !stall_ID_EX) begin
            if (wr_vld && (dst_addr_DM_WB == p0_addr)) p0_d = rf_w_data_DM_WB;
            else                                       p0_d = regs_q[p0_addr];
            p0_busy_d = busy_d[p0_addr];
        end

        if (re1 && !stall_ID_EX) begin
            if (wr_vld && (dst_addr_DM_WB == p1_addr)) p1_d = rf_w_data_DM_WB;
            else                                       p1_d = regs_q[p1_addr];
            p1_busy_d = busy_d[p1_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            busy_q    <= '0;
            p0_q      <= '0;
            p1_q      <= '0;
            p0_busy_q <= 1'b0;
            p1_busy_q <= 1'b0;
        end else begin
            if (wr_vld) regs_q[dst_addr_DM_WB] <= rf_w_data_DM_WB;
            busy_q    <= busy_d;
            p0_q      <= p0_d;
            p1_q      <= p1_d;
            p0_busy_q <= p0_busy_d;
            p1_busy_q <= p1_busy_d;
        end
    end

    assign p0      = p0_q;
    assign p1      = p1_q;
    assign p0_busy = p0_busy_q;
    assign p1_busy = p1_busy_q;

endmodule

// File: tb/tb_rf_wb_sink.sv
// Bench for rf_wb_sink: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a register-file model.
module tb_rf_wb_sink;

    localparam int DW = 16;
    localparam int NR = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          we;
    logic [AW-1:0] dst;
    logic [DW-1:0] wdat;
    logic          re0, re1;
    logic [AW-1:0] a0, a1;
    logic          stall;
    logic          pset;
    logic [AW-1:0] paddr;
    logic [DW-1:0] p0, p1;
    logic          p0_busy, p1_busy;

    rf_wb_sink #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .we_DM_WB       (we),
        .dst_addr_DM_WB (dst),
        .rf_w_data_DM_WB(wdat),
        .re0            (re0),
        .re1            (re1),
        .p0_addr        (a0),
        .p1_addr        (a1),
        .stall_ID_EX    (stall),
        .pend_set       (pset),
        .pend_addr      (paddr),
        .p0             (p0),
        .p1             (p1),
        .p0_busy        (p0_busy),
        .p1_busy        (p1_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: architectural state plus what each port should currently show.
    logic [DW-1:0] m_reg [NR];
    bit            m_busy [NR];
    logic [DW-1:0] e_p0, e_p1;
    logic          e_b0, e_b1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reads observe the register file as it stands after this cycle's write
    // and scoreboard update, which is what bypass and busy semantics amount to.
    task automatic model_step();
        if (rst) begin
            for (int i = 0; i < NR; i++) begin
                m_reg[i]  = '0;
                m_busy[i] = 1'b0;
            end
            e_p0 = '0; e_p1 = '0; e_b0 = 1'b0; e_b1 = 1'b0;
        end else begin
            if (we && dst != 0) begin
                m_reg[dst]  = wdat;
                m_busy[dst] = 1'b0;
            end
            if (pset && paddr != 0) m_busy[paddr] = 1'b1;
            if (re0 && !stall) begin e_p0 = m_reg[a0]; e_b0 = m_busy[a0]; end
            if (re1 && !stall) begin e_p1 = m_reg[a1]; e_b1 = m_busy[a1]; end
        end
    endtask

    task automatic compare_all();
        chk("p0", p0, e_p0);
        chk("p1", p1, e_p1);
        chk("p0_busy", {15'd0, p0_busy}, {15'd0, e_b0});
        chk("p1_busy", {15'd0, p1_busy}, {15'd0, e_b1});
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();
        rst = 0; we = 0; dst = '0; wdat = '0; re0 = 0; re1 = 0;
        a0 = '0; a1 = '0; stall = 0; pset = 0; paddr = '0;
    endtask

    task automatic wr(input logic [AW-1:0] d, input logic [DW-1:0] v);
        idle(); we = 1; dst = d; wdat = v;
        step();
    endtask

    task automatic lit(input string name, input logic [DW-1:0] dut_v,
                       input logic [DW-1:0] mdl_v, input logic [DW-1:0] exp);
        chk({name, "_dut"}, dut_v, exp);
        chk({name, "_model"}, mdl_v, exp);
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin m_reg[i] = 'x; m_busy[i] = 1'b0; end
        e_p0 = 'x; e_p1 = 'x; e_b0 = 1'bx; e_b1 = 1'bx;
        @(negedge clk);
        idle(); rst = 1;
        step();
        lit("rst_p0", p0, e_p0, 16'h0000);
        lit("rst_b0", {15'd0, p0_busy}, {15'd0, e_b0}, 16'h0000);

        // All registers read zero after reset.
        for (int r = 1; r < NR; r++) begin
            idle(); re0 = 1; re1 = 1; a0 = AW'(r); a1 = AW'(r);
            step();
            lit("rst_rd_p0", p0, e_p0, 16'h0000);
            lit("rst_rd_p1", p1, e_p1, 16'h0000);
        end
        wr(4'd3, 16'hBEEF);
        idle(); re0 = 1; a0 = 4'd3;
        step();
        lit("r3_read", p0, e_p0, 16'hBEEF);

        // R0 ignores writes and is never busy.
        wr(4'd0, 16'h1234);
        idle(); re0 = 1; a0 = 4'd0; pset = 1; paddr = 4'd0;
        step();
        lit("r0_read", p0, e_p0, 16'h0000);
        lit("r0_busy", {15'd0, p0_busy}, {15'd0, e_b0}, 16'h0000);

        // Bypass on both ports, then one port bypassing while the other reads R6.
        wr(4'd6, 16'h0666);
        idle(); we = 1; dst = 4'd5; wdat = 16'hA5A5; re0 = 1; re1 = 1; a0 = 4'd5; a1 = 4'd5;
        step();
        lit("byp_p0", p0, e_p0, 16'hA5A5);
        lit("byp_p1", p1, e_p1, 16'hA5A5);
        idle(); we = 1; dst = 4'd5; wdat = 16'h5A5A; re0 = 1; re1 = 1; a0 = 4'd5; a1 = 4'd6;
        step();
        lit("byp2_p0", p0, e_p0, 16'h5A5A);
        lit("byp2_p1", p1, e_p1, 16'h0666);

        // Stall holds the previous read across an address change.
        wr(4'd7, 16'h0007);
        wr(4'd8, 16'h0008);
        idle(); re0 = 1; a0 = 4'd7;
        step();
        lit("stall_pre", p0, e_p0, 16'h0007);
        for (int k = 0; k < 3; k++) begin
            idle(); re0 = 1; a0 = 4'd8; stall = 1;
            step();
            lit("stall_hold", p0, e_p0, 16'h0007);
        end
        idle(); re0 = 1; a0 = 4'd8;
        step();
        lit("stall_rel", p0, e_p0, 16'h0008);

        // Scoreboard set, clear-with-bypass, and set winning over clear.
        idle(); pset = 1; paddr = 4'd4;
        step();
        idle(); re0 = 1; a0 = 4'd4;
        step();
        lit("sb_set", {15'd0, p0_busy}, {15'd0, e_b0}, 16'h0001);
        idle(); we = 1; dst = 4'd4; wdat = 16'h4444; re0 = 1; a0 = 4'd4;
        step();
        lit("sb_clr_busy", {15'd0, p0_busy}, {15'd0, e_b0}, 16'h0000);
        lit("sb_clr_data", p0, e_p0, 16'h4444);
        idle(); we = 1; dst = 4'd4; wdat = 16'h4545; pset = 1; paddr = 4'd4; re0 = 1; a0 = 4'd4;
        step();
        lit("sb_win_busy", {15'd0, p0_busy}, {15'd0, e_b0}, 16'h0001);
        idle(); re0 = 1; a0 = 4'd4;
        step();
        lit("sb_win_hold", {15'd0, p0_busy}, {15'd0, e_b0}, 16'h0001);

        // Reset in the middle of traffic dominates a simultaneous write.
        wr(4'd2, 16'h0222);
        idle(); pset = 1; paddr = 4'd2; step();
        idle(); pset = 1; paddr = 4'd9; re0 = 1; a0 = 4'd2; re1 = 1; a1 = 4'd9; step();
        lit("mid_busy2", {15'd0, p0_busy}, {15'd0, e_b0}, 16'h0001);
        lit("mid_r2", p0, e_p0, 16'h0222);
        idle(); rst = 1; we = 1; dst = 4'd2; wdat = 16'hFFFF; re0 = 1; a0 = 4'd2;
        step();
        lit("mid_rst_p0", p0, e_p0, 16'h0000);
        lit("mid_rst_b1", {15'd0, p1_busy}, {15'd0, e_b1}, 16'h0000);
        idle(); re0 = 1; a0 = 4'd2; re1 = 1; a1 = 4'd9;
        step();
        lit("post_rst_r2", p0, e_p0, 16'h0000);
        lit("post_rst_b2", {15'd0, p0_busy}, {15'd0, e_b0}, 16'h0000);
        lit("post_rst_b9", {15'd0, p1_busy}, {15'd0, e_b1}, 16'h0000);

        // Randomized traffic; narrow address range half the time for collisions.
        for (int n = 0; n < 3000; n++) begin
            bit narrow;
            narrow = ($urandom_range(1) == 1);
            rst   = ($urandom_range(99) == 0);
            we    = ($urandom_range(1) == 1);
            dst   = narrow ? AW'($urandom_range(3)) : AW'($urandom_range(NR - 1));
            wdat  = DW'($urandom);
            re0   = ($urandom_range(3) != 0);
            re1   = ($urandom_range(3) != 0);
            a0    = narrow ? AW'($urandom_range(3)) : AW'($urandom_range(NR - 1));
            a1    = narrow ? AW'($urandom_range(3)) : AW'($urandom_range(NR - 1));
            stall = ($urandom_range(4) == 0);
            pset  = ($urandom_range(2) == 0);
            paddr = narrow ? AW'($urandom_range(3)) : AW'($urandom_range(NR - 1));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
